alt_vipcti131_common_frame_burst_writer: RTL and testbench

- Upstream command/data generator for the common Avalon-MM bursting master's user interface.
- Takes a frame-write request (base address, word count) and a pixel-word stream with valid/ready.
- Splits the frame into write bursts of at most BURST_TARGET words and drives addr, command, burst_length, writedata and write into the master.
- Honours the master's stall and signals completion with a done pulse.

---
 rtl/alt_vipcti131_common_frame_burst_writer.sv | 164 ++++++++++++++++
 tb/tb_alt_vipcti131_common_frame_burst_writer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alt_vipcti131_common_frame_burst_writer.sv
// Frame burst writer: splits a frame write request into Avalon-MM write bursts
// of at most BURST_TARGET words and streams pixel words into the bursting master.
module alt_vipcti131_common_frame_burst_writer #(
    parameter int ADDR_WIDTH                     = 16,
    parameter int DATA_WIDTH                     = 16,
    parameter int LEN_WIDTH                      = 24,
    parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
    parameter int BURST_TARGET                   = 32,
    parameter int ADDR_INCREMENT                 = 2
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic [LEN_WIDTH-1:0]                      frame_words,
    input  logic [DATA_WIDTH-1:0]                     din_data,
    input  logic                                      din_valid,
    output logic                                      din_ready,
    output logic [ADDR_WIDTH-1:0]                     addr,
    output logic                                      command,
    output logic                                      is_burst,
    output logic                                      is_write_not_read,
    output logic [MAX_BURST_LENGTH_REQUIREDWIDTH-1:0] burst_length,
    output logic [DATA_WIDTH-1:0]                     writedata,
    output logic                                      write,
    input  logic                                      stall,
    output logic                                      busy,
    output logic                                      done
);
    localparam int BLW = MAX_BURST_LENGTH_REQUIREDWIDTH;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [BLW-1:0]          beats_q, beats_d;
    logic [BLW-1:0]          burst_length_q, burst_length_d;
    logic                    command_q, command_d;
    logic                    is_burst_q, is_burst_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    beat_ok;
    logic                    last_beat;
    logic [LEN_WIDTH-1:0]    rem_after;
    logic [ADDR_WIDTH-1:0]   addr_after;
    logic [BLW-1:0]          first_len;
    logic [BLW-1:0]          next_len;

    function automatic logic [BLW-1:0] clamp_burst(input logic [LEN_WIDTH-1:0] words);
        if (words > LEN_WIDTH'(BURST_TARGET))
            return BLW'(BURST_TARGET);
        return BLW'(words);
    endfunction

    assign beat_ok    = (state_q == DATA) && din_valid && !stall;
    assign last_beat  = beat_ok && (beats_q == BLW'(1));
    assign rem_after  = remaining_q - LEN_WIDTH'(burst_length_q);
    // Address arithmetic is modulo 2^ADDR_WIDTH; a frame may wrap past the top.
    assign addr_after = cur_addr_q + ADDR_WIDTH'(burst_length_q) * ADDR_WIDTH'(ADDR_INCREMENT);
    assign first_len  = clamp_burst(remaining_q);
    assign next_len   = clamp_burst(rem_after);

    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        beats_d        = beats_q;
        burst_length_d = burst_length_q;
        command_d      = command_q;
        is_burst_d     = is_burst_q;
        busy_d         = busy_q;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d  = base_addr;
                    remaining_d = frame_words;
                    busy_d      = 1'b1;
                    state_d     = (frame_words == '0) ? DONE : CMD;
                end
            end
            CMD: begin
                // First entry after start registers the burst; later entries arrive pre-loaded.
                if (!command_q) begin
                    if (!stall) begin
                        burst_length_d = first_len;
                        addr_d         = cur_addr_q;
                        is_burst_d     = first_len > BLW'(1);
                        command_d      = 1'b1;
                    end
                end else if (!stall) begin
                    command_d = 1'b0;
                    beats_d   = burst_length_q;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (beat_ok)
                    beats_d = beats_q - BLW'(1);
                if (last_beat) begin
                    remaining_d = rem_after;
                    cur_addr_d  = addr_after;
                    if (rem_after == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d        = CMD;
                        burst_length_d = next_len;
                        addr_d         = addr_after;
                        is_burst_d     = next_len > BLW'(1);
                        command_d      = 1'b1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            cur_addr_q     <= '0;
            addr_q         <= '0;
            remaining_q    <= '0;
            beats_q        <= '0;
            burst_length_q <= '0;
            command_q      <= 1'b0;
            is_burst_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_addr_q     <= cur_addr_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            beats_q        <= beats_d;
            burst_length_q <= burst_length_d;
            command_q      <= command_d;
            is_burst_q     <= is_burst_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign addr              = addr_q;
    assign command           = command_q;
    assign is_burst          = is_burst_q;
    assign is_write_not_read = 1'b1;
    assign burst_length      = burst_length_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign din_ready         = (state_q == DATA) && !stall;
    assign write             = (state_q == DATA) && din_valid;
    assign writedata         = din_data;

endmodule

// File: tb/tb_alt_vipcti131_common_frame_burst_writer.sv
// Bench for the frame burst writer: directed and randomized frames checked
// against a burst-list / word-stream reference model.
module tb_alt_vipcti131_common_frame_burst_writer;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LW  = 24;
    localparam int BLW = 11;
    localparam int BT  = 32;
    localparam int INC = 2;
    localparam int LIMIT = 4000;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic [LW-1:0]  frame_words;
    logic [DW-1:0]  din_data;
    logic           din_valid;
    logic           din_ready;
    logic [AW-1:0]  addr;
    logic           command;
    logic           is_burst;
    logic           is_write_not_read;
    logic [BLW-1:0] burst_length;
    logic [DW-1:0]  writedata;
    logic           write;
    logic           stall;
    logic           busy;
    logic           done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] a;
        int            len;
    } cmd_t;

    always #5 clock = ~clock;

    alt_vipcti131_common_frame_burst_writer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
        .MAX_BURST_LENGTH_REQUIREDWIDTH(BLW), .BURST_TARGET(BT), .ADDR_INCREMENT(INC)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .frame_words(frame_words), .din_data(din_data), .din_valid(din_valid),
        .din_ready(din_ready), .addr(addr), .command(command), .is_burst(is_burst),
        .is_write_not_read(is_write_not_read), .burst_length(burst_length),
        .writedata(writedata), .write(write), .stall(stall), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_command"}, command, 0);
        check({tag, "_write"}, write, 0);
        check({tag, "_din_ready"}, din_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_burst_length"}, burst_length, 0);
        check({tag, "_is_burst"}, is_burst, 0);
    endtask

    // vmode: 0 valid always, 1 toggling, 2 random. smode: 0 none, 1 two 5-cycle windows, 2 random.
    task automatic run_frame(input logic [AW-1:0] base, input int words, input int vmode,
                             input int smode, input int abort_at);
        cmd_t          exp_cmds[$];
        logic [DW-1:0] src[$];
        logic [DW-1:0] got[$];
        int  cyc = 0, ncmd = 0, writes = 0, outstanding = 0, done_cnt = 0;
        int  first_cmd = -1, done_cyc = -1, exp_done = 2, stall_left = 0;
        bit  cmd_win_used = 0, data_win_used = 0, in_data;
        logic          prev_stall = 0, prev_cmd = 0;
        logic [AW-1:0] prev_addr = '0;
        logic [BLW-1:0] prev_bl = '0;
        logic [DW-1:0] pending;

        for (int off = 0; off < words; off += BT) begin
            cmd_t c;
            c.a   = base + AW'(off * INC);
            c.len = (words - off < BT) ? (words - off) : BT;
            exp_cmds.push_back(c);
            exp_done += 1 + c.len;
        end
        if (words > 0) exp_done += 1;
        pending = DW'($urandom);

        @(negedge clock);
        while (1) begin
            if (abort_at > 0 && writes == abort_at) begin
                reset = 1'b1; start = 1'b0; stall = 1'b0;
                @(posedge clock); #1;
                check_reset_outputs("abort");
                @(negedge clock);
                reset = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    check("abort_no_done", done, 0);
                    check("abort_no_command", command, 0);
                    @(negedge clock);
                end
                return;
            end

            in_data = outstanding > 0;
            if (cyc == 0) begin
                start = 1'b1; base_addr = base; frame_words = LW'(words);
            end else begin
                base_addr   = AW'($urandom);
                frame_words = LW'($urandom_range(1, 200));
                start = 1'b0;
                if (smode == 2 && in_data) start = ($urandom_range(0, 3) == 0);
                if (vmode == 0 && smode == 0 && cyc == exp_done - 1) start = 1'b1;
            end
            if (smode == 1 && !cmd_win_used && command) begin
                stall_left = 5; cmd_win_used = 1;
            end
            if (smode == 1 && !data_win_used && writes == 10) begin
                stall_left = 5; data_win_used = 1;
            end
            if (smode == 2) stall = ($urandom_range(0, 3) == 0);
            else            stall = (stall_left > 0);
            case (vmode)
                0:       din_valid = 1'b1;
                1:       din_valid = (cyc % 2 == 0);
                default: din_valid = ($urandom_range(0, 1) == 1);
            endcase
            din_data = pending;
            #1;

            if (prev_cmd && prev_stall) begin
                check("stall_hold_command", command, 1);
                check("stall_hold_addr", addr, prev_addr);
                check("stall_hold_burst_length", burst_length, prev_bl);
            end
            check("write_follows_valid", write, in_data && din_valid);
            check("din_ready", din_ready, in_data && !stall);
            if (in_data) check("no_cmd_during_data", command, 0);
            check("busy", busy, (cyc >= 1) && !done);
            check("is_write_not_read", is_write_not_read, 1);

            if (write && !stall) begin
                got.push_back(writedata);
                src.push_back(pending);
                writes++;
                outstanding--;
                pending = DW'($urandom);
            end
            if (command && !stall) begin
                if (ncmd < exp_cmds.size()) begin
                    check("cmd_addr", addr, exp_cmds[ncmd].a);
                    check("cmd_burst_length", burst_length, exp_cmds[ncmd].len);
                    check("cmd_is_burst", is_burst, exp_cmds[ncmd].len > 1);
                end
                ncmd++;
                outstanding = int'(burst_length);
                if (first_cmd < 0) first_cmd = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end

            prev_stall = stall; prev_cmd = command; prev_addr = addr; prev_bl = burst_length;
            @(posedge clock);
            if (stall_left > 0) stall_left--;
            cyc++;
            if (done_cyc >= 0 || cyc > LIMIT) break;
            @(negedge clock);
        end

        start = 1'b0; stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); #1;
            check("idle_busy", busy, 0);
            check("idle_command", command, 0);
            if (done) done_cnt++;
        end
        check("done_count", done_cnt, 1);
        check("command_count", ncmd, exp_cmds.size());
        check("write_count", writes, words);
        for (int i = 0; i < got.size() && i < src.size(); i++)
            check("writedata", got[i], src[i]);
        if (vmode == 0 && smode == 0) begin
            check("done_latency", done_cyc, exp_done);
            if (words > 0) check("first_cmd_latency", first_cmd, 2);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; frame_words = '0;
        din_data = '0; din_valid = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        run_frame(16'h1000, 70, 0, 0, 0);
        run_frame(16'h2000, 0, 0, 0, 0);
        run_frame(16'h3000, 1, 0, 0, 0);
        run_frame(16'h4000, 32, 0, 1, 0);
        run_frame(16'h5000, 32, 1, 0, 0);
        run_frame(16'h1000, 70, 0, 0, 40);
        run_frame(16'hFFF0, 16, 0, 0, 0);
        run_frame(16'hFFF0, 40, 0, 0, 0);
        for (int n = 0; n < 6; n++)
            run_frame(AW'($urandom), $urandom_range(1, 150), 2, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
